// File: rtl/stack_controller.sv
// stack_controller: multicycle Moore control FSM for the 8-bit stack CPU.
// Define CTRL_PERF_EN to add the instr_count fetch counter output.
module stack_controller #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcSrc,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       MtoS,
    output logic       ldA,
    output logic       ldB,
    output logic       srcA,
    output logic       srcB,
    output logic       push,
    output logic       pop,
    output logic       tos,
    output logic [1:0] ALUOp,
    output logic [3:0] state
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        POPA   = 4'd2,
        POPB   = 4'd3,
        EXEC   = 4'd4,
        WB     = 4'd5,
        MRD    = 4'd6,
        MPUSH  = 4'd7,
        MWR    = 4'd8,
        JMP    = 4'd9,
        TOS    = 4'd10,
        BR     = 4'd11
    } state_e;

    state_e state_q, state_d;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    always_comb begin
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = !opcode[2] ? POPA :
                               opcode == 3'b100 ? MRD :
                               opcode == 3'b101 ? POPA :
                               opcode == 3'b110 ? JMP : TOS;
            POPA:    state_d = opcode == 3'b011 ? EXEC :
                               opcode == 3'b101 ? MWR : POPB;
            POPB:    state_d = EXEC;
            EXEC:    state_d = WB;
            MRD:     state_d = MPUSH;
            TOS:     state_d = BR;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    // Outputs are forced low while rst is held, even though state already reads FETCH.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSrc       = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        MtoS        = 1'b0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        srcA        = 1'b0;
        srcB        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        tos         = 1'b0;
        ALUOp       = 2'b00;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    memRead = 1'b1;
                    IRWrite = 1'b1;
                    srcA    = 1'b1;
                    srcB    = 1'b1;
                    pcWrite = 1'b1;
                end
                POPA: begin
                    pop = 1'b1;
                    ldA = 1'b1;
                end
                POPB: begin
                    pop = 1'b1;
                    ldB = 1'b1;
                end
                EXEC:  ALUOp = opcode[1:0];
                WB:    push = 1'b1;
                MRD: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                end
                MPUSH: begin
                    MtoS = 1'b1;
                    push = 1'b1;
                end
                MWR: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                end
                JMP: begin
                    pcSrc   = 1'b1;
                    pcWrite = 1'b1;
                end
                TOS:   tos = 1'b1;
                BR: begin
                    pcSrc       = 1'b1;
                    pcWriteCond = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt_q <= '0;
        else if (state_q == FETCH) cnt_q <= cnt_q + 1'b1;
    end

    assign instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: directed and random instructions checked against a spec-level sequence/strobe model.
module tb_stack_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic       ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;
    logic [3:0] state;
`ifdef CTRL_PERF_EN
    logic [3:0] instr_count;
    int         cnt_m = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
        logic ldA, ldB, srcA, srcB, push, pop, tos;
        logic [1:0] alu;
    } ctrl_t;

    stack_controller #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
        .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB), .push(push), .pop(pop),
        .tos(tos), .ALUOp(ALUOp), .state(state)
`ifdef CTRL_PERF_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic ctrl_t observed();
        return {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                ldA, ldB, srcA, srcB, push, pop, tos, ALUOp};
    endfunction

    function automatic ctrl_t expected_ctrl(int s, logic [2:0] op);
        ctrl_t c = '0;
        case (s)
            0: begin c.memRead = 1; c.IRWrite = 1; c.srcA = 1; c.srcB = 1; c.pcWrite = 1; end
            2: begin c.pop = 1; c.ldA = 1; end
            3: begin c.pop = 1; c.ldB = 1; end
            4: c.alu = op[1:0];
            5: c.push = 1;
            6: begin c.IorD = 1; c.memRead = 1; end
            7: begin c.MtoS = 1; c.push = 1; end
            8: begin c.IorD = 1; c.memWrite = 1; end
            9: begin c.pcSrc = 1; c.pcWrite = 1; end
            10: c.tos = 1;
            11: begin c.pcSrc = 1; c.pcWriteCond = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag);
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " ctrl"}, 32'(observed()), 32'(expected_ctrl(0, opcode)));
`ifdef CTRL_PERF_EN
        check({tag, " instr_count"}, 32'(instr_count), 32'(cnt_m));
`endif
    endtask

    // Issue one instruction from a FETCH sampling point and follow it back to FETCH.
    task automatic run_instr(input logic [2:0] op);
        int seq[6];
        int n;
        int pops = 0;
        int pushes = 0;
        string t;
        case (op)
            3'd0, 3'd1, 3'd2: begin seq = '{1, 2, 3, 4, 5, 0}; n = 5; end
            3'd3:             begin seq = '{1, 2, 4, 5, 0, 0}; n = 4; end
            3'd4:             begin seq = '{1, 6, 7, 0, 0, 0}; n = 3; end
            3'd5:             begin seq = '{1, 2, 8, 0, 0, 0}; n = 3; end
            3'd6:             begin seq = '{1, 9, 0, 0, 0, 0}; n = 2; end
            default:          begin seq = '{1, 10, 11, 0, 0, 0}; n = 3; end
        endcase
        t = $sformatf("op%0d", op);
        check_fetch({t, " fetch"});
        opcode = op;
        @(negedge clk);
`ifdef CTRL_PERF_EN
        cnt_m = (cnt_m + 1) % 16;
`endif
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s step%0d state", t, i), 32'(state), 32'(seq[i]));
            check($sformatf("%s step%0d ctrl", t, i), 32'(observed()), 32'(expected_ctrl(seq[i], op)));
            check($sformatf("%s step%0d excl", t, i),
                  32'({push & pop, memRead & memWrite, pcWrite & pcWriteCond}), 32'd0);
            pops += int'(pop);
            pushes += int'(push);
            @(negedge clk);
        end
        check({t, " pops"}, 32'(pops), (op <= 3'd2) ? 32'd2 : (op == 3'd3 || op == 3'd5) ? 32'd1 : 32'd0);
        check({t, " pushes"}, 32'(pushes), (op <= 3'd4) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(observed()), 32'd0);
        rst = 1'b0;
        #1;
        // Reset mid-EXEC of an ADD aborts it; outputs drop at once.
        opcode = 3'b000;
        check_fetch("pre-abort fetch");
        repeat (4) @(negedge clk);
        check("abort at exec", 32'(state), 32'd4);
        rst = 1'b1;
        #1;
        check("async rst state", 32'(state), 32'd0);
        check("async rst ctrl", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        check("held rst ctrl", 32'(observed()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef CTRL_PERF_EN
        cnt_m = 0;
`endif
        #1;
        check_fetch("post-reset fetch");
        for (int op = 0; op < 8; op++) run_instr(3'(op));
        repeat (30) run_instr(3'($urandom_range(7, 0)));
        check_fetch("final fetch");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
